// File: rtl/acc_frame_summer.sv
// acc_frame_summer: sums COUNT 3-bit adder results into one 8-bit frame total.
// Valid/ready on both sides; the frame total is offered in EMIT until taken.
// Optional build macro: ACC_SATURATE_EN (clamp the total at 255 instead of wrapping).
module acc_frame_summer #(
  parameter int COUNT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  localparam logic [7:0] COUNT_W = 8'(COUNT);

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;

  logic [8:0] sum;
  logic [7:0] acc_add;
  logic [7:0] cnt_inc;
  logic       in_xfer;
  logic       out_xfer;

  // Handshake qualifiers; ready/valid come straight from the state register.
  always_comb begin
    in_ready  = (state_q != EMIT);
    out_valid = (state_q == EMIT);
    in_xfer   = in_valid & in_ready;
    out_xfer  = out_valid & out_ready;
  end

  // 9-bit sum exposes the carry out of bit 7 used for overflow and clamping.
  always_comb begin
    sum     = {1'b0, acc_q} + {6'b0, in_data};
    cnt_inc = cnt_q + 8'd1;
`ifdef ACC_SATURATE_EN
    acc_add = sum[8] ? 8'hFF : sum[7:0];
`else
    acc_add = sum[7:0];
`endif
  end

  // Next-state and datapath updates; everything holds unless a transfer happens.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          acc_d   = {5'b0, in_data};
          cnt_d   = 8'd1;
          ovf_d   = 1'b0;
          state_d = (COUNT_W == 8'd1) ? EMIT : ACCUM;
        end
      end
      ACCUM: begin
        if (in_xfer) begin
          acc_d = acc_add;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | sum[8];
          if (cnt_inc == COUNT_W) state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_xfer) begin
          acc_d   = 8'd0;
          cnt_d   = 8'd0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        acc_d   = 8'd0;
        cnt_d   = 8'd0;
        ovf_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial or pending frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= 8'd0;
      cnt_q   <= 8'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Total and flag are only visible while the frame is being offered.
  always_comb begin
    out_data     = (state_q == EMIT) ? acc_q : 8'd0;
    out_overflow = (state_q == EMIT) ? ovf_q : 1'b0;
  end

endmodule

// File: tb/tb_acc_frame_summer.sv
// Bench for acc_frame_summer: three instances (COUNT = 4, 40, 1) share clock,
// reset, data and out_ready; each has its own in_valid. Expected totals come
// from a plain integer sum of the samples of each frame.
module tb_acc_frame_summer;

`ifdef ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] in_data = 3'd0;
  logic       out_ready = 1'b0;
  logic       iv [3];
  logic       ir [3];
  logic       ov [3];
  logic [7:0] od [3];
  logic       oo [3];

  int vectors = 0;
  int miscompares = 0;
  int sel = 0;

  always #5 clock = ~clock;

  acc_frame_summer #(.COUNT(4)) u_c4 (
    .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_overflow(oo[0]));
  acc_frame_summer #(.COUNT(40)) u_c40 (
    .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_overflow(oo[1]));
  acc_frame_summer #(.COUNT(1)) u_c1 (
    .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_overflow(oo[2]));

  // Frame total as the specification defines it from the true integer sum.
  function automatic void model(input int total, output logic [7:0] d, output logic o);
    o = (total > 255);
    if (!o)      d = 8'(total);
    else if (SAT) d = 8'hFF;
    else          d = 8'(total % 256);
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Offer one sample to the selected instance and return just after it is taken.
  task automatic push(input logic [2:0] d);
    int n;
    n = 0;
    iv[sel] = 1'b1;
    in_data = d;
    while (!ir[sel] && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL push_timeout sel=%0d in_ready stuck at %0b, required 1", sel, ir[sel]);
    end
    tick();
    iv[sel] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (ov[k] !== 1'b0 || od[k] !== 8'd0 || oo[k] !== 1'b0 || ir[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_state inst=%0d got v=%0b d=%0d o=%0b r=%0b, required 0 0 0 1",
                 k, ov[k], od[k], oo[k], ir[k]);
      end
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] s [4];
    s[0] = 3'd6; s[1] = 3'd2; s[2] = 3'd0; s[3] = 3'd5;
    sel = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(s[i]);
      if (i < 3) begin
        vectors++;
        if (ov[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_early_valid after sample %0d got %0b, required 0", i, ov[0]);
        end
      end
    end
    vectors++;
    if (ov[0] !== 1'b1 || od[0] !== 8'd13 || oo[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_total got v=%0b d=%0d o=%0b, required 1 13 0", ov[0], od[0], oo[0]);
    end
    tick();
    out_ready = 1'b0;
    vectors++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || od[0] !== 8'd0) begin
      miscompares++;
      $display("FAIL b2b_return got v=%0b r=%0b d=%0d, required 0 1 0", ov[0], ir[0], od[0]);
    end
  endtask

  task automatic test_gaps_stall();
    sel = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (2) tick();
      push(3'd3);
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (ov[0] !== 1'b1 || od[0] !== 8'd12 || oo[0] !== 1'b0 || ir[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold cycle=%0d got v=%0b d=%0d o=%0b r=%0b, required 1 12 0 0",
                 k, ov[0], od[0], oo[0], ir[0]);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || od[0] !== 8'd0) begin
      miscompares++;
      $display("FAIL stall_release got v=%0b r=%0b d=%0d, required 0 1 0", ov[0], ir[0], od[0]);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] ed;
    logic       eo;
    sel = 1;
    out_ready = 1'b0;
    for (int i = 0; i < 40; i++) push(3'd7);
    model(280, ed, eo);
    vectors++;
    if (ov[1] !== 1'b1 || od[1] !== ed || oo[1] !== eo) begin
      miscompares++;
      $display("FAIL overflow_total got v=%0b d=%0d o=%0b, required 1 %0d %0b",
               ov[1], od[1], oo[1], ed, eo);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (oo[1] !== 1'b0 || ov[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clear got v=%0b o=%0b, required 0 0", ov[1], oo[1]);
    end
  endtask

  task automatic test_count1();
    sel = 2;
    out_ready = 1'b0;
    push(3'd5);
    vectors++;
    if (ov[2] !== 1'b1 || od[2] !== 8'd5) begin
      miscompares++;
      $display("FAIL c1_total got v=%0b d=%0d, required 1 5", ov[2], od[2]);
    end
    iv[2] = 1'b1;
    in_data = 3'd3;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (ir[2] !== 1'b0 || od[2] !== 8'd5 || ov[2] !== 1'b1) begin
        miscompares++;
        $display("FAIL c1_no_bypass cycle=%0d got r=%0b v=%0b d=%0d, required 0 1 5",
                 k, ir[2], ov[2], od[2]);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (ov[2] !== 1'b0 || ir[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL c1_idle got v=%0b r=%0b, required 0 1", ov[2], ir[2]);
    end
    tick();
    iv[2] = 1'b0;
    vectors++;
    if (ov[2] !== 1'b1 || od[2] !== 8'd3) begin
      miscompares++;
      $display("FAIL c1_waiting_sample got v=%0b d=%0d, required 1 3", ov[2], od[2]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel = 0;
    out_ready = 1'b0;
    for (int phase = 0; phase < 2; phase++) begin
      // phase 0: two samples in flight; phase 1: a full frame pending in EMIT
      for (int i = 0; i < (phase == 0 ? 2 : 4); i++) push(3'd2);
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (ov[0] !== 1'b0 || od[0] !== 8'd0 || oo[0] !== 1'b0 || ir[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL midreset_outputs phase=%0d got v=%0b d=%0d o=%0b r=%0b, required 0 0 0 1",
                 phase, ov[0], od[0], oo[0], ir[0]);
      end
      tick();
      reset = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) push(3'd1);
      vectors++;
      if (ov[0] !== 1'b1 || od[0] !== 8'd4 || oo[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_fresh phase=%0d got v=%0b d=%0d o=%0b, required 1 4 0",
                 phase, ov[0], od[0], oo[0]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_random();
    int total, cnt, stall;
    logic [2:0] d;
    logic [7:0] ed;
    logic       eo;
    for (int f = 0; f < 18; f++) begin
      sel = f % 3;
      cnt = (sel == 0) ? 4 : (sel == 1) ? 40 : 1;
      total = 0;
      out_ready = 1'b0;
      for (int i = 0; i < cnt; i++) begin
        d = 3'($urandom_range(0, 7));
        total += int'(d);
        repeat ($urandom_range(0, 2)) tick();
        push(d);
        if (i < cnt - 1) begin
          vectors++;
          if (ov[sel] !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_early_valid frame=%0d sample=%0d got %0b, required 0", f, i, ov[sel]);
          end
        end
      end
      model(total, ed, eo);
      stall = $urandom_range(0, 3);
      for (int k = 0; k <= stall; k++) begin
        vectors++;
        if (ov[sel] !== 1'b1 || od[sel] !== ed || oo[sel] !== eo || ir[sel] !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_total frame=%0d sum=%0d got v=%0b d=%0d o=%0b r=%0b, required 1 %0d %0b 0",
                   f, total, ov[sel], od[sel], oo[sel], ir[sel], ed, eo);
        end
        if (k < stall) tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if (ov[sel] !== 1'b0 || od[sel] !== 8'd0 || oo[sel] !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_idle frame=%0d got v=%0b d=%0d o=%0b, required 0 0 0",
                 f, ov[sel], od[sel], oo[sel]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) iv[k] = 1'b0;
    #3;
    test_reset();
    test_back_to_back();
    test_gaps_stall();
    test_overflow();
    test_count1();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/acc_frame_summer.md
ACC_FRAME_SUMMER -- requirements
Module: acc_frame_summer

Interface
REQ-001 SHALL have parameter: COUNT, default 4, samples per frame; legal range 1..255.
REQ-002 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  upstream 3-bit adder result valid.
REQ-005 SHALL have port: in_ready  output  1  block accepts a sample this cycle.
REQ-006 SHALL have port: in_data  input  3  unsigned adder sum (0..7 accepted; adder produces 0..6).
REQ-007 SHALL have port: out_valid  output  1  frame total available.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts total.
REQ-009 SHALL have port: out_data  output  8  frame total.
REQ-010 SHALL have port: out_overflow  output  1  total exceeded 255 during this frame.

Function
REQ-011 SHALL implement three states: IDLE, ACCUM, EMIT.
REQ-012 SHALL define input transfer as in_valid & in_ready in the same cycle; output transfer as out_valid & out_ready.
REQ-013 SHALL drive in_ready=1 in IDLE and ACCUM, 0 in EMIT (no bypass; a sample offered in EMIT waits).
REQ-014 SHALL, on input transfer in IDLE, load acc=zero-extended in_data, cnt=1, clear overflow flag; next state EMIT if COUNT==1, else ACCUM.
REQ-015 SHALL, on input transfer in ACCUM, set acc=acc+zext(in_data) (8-bit), cnt=cnt+1; next state EMIT when new cnt==COUNT, else stay.
REQ-016 SHALL hold acc, cnt and state unchanged in IDLE/ACCUM cycles without input transfer (gaps of any length allowed).
REQ-017 SHALL assert out_valid exactly in EMIT; out_valid rises the cycle after the COUNT-th input transfer (latency 1).
REQ-018 SHALL hold out_data=acc and out_overflow stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, on output transfer, return to IDLE, clear acc, cnt and overflow flag; a new sample is acceptable the following cycle.
REQ-020 SHALL drive out_data=0 and out_overflow=0 whenever out_valid=0.
REQ-021 SHALL set the overflow flag when any addition in the frame carries out of bit 7; flag sticky until frame end.
REQ-022 SHALL wrap acc modulo 256 on carry-out (default build, see REQ-026).
REQ-023 SHALL use cnt width 8; no other wrap of cnt is possible given REQ-001.

Reset
REQ-024 SHALL, on reset assertion, immediately force state=IDLE, acc=0, cnt=0, overflow=0, out_valid=0, out_data=0, out_overflow=0, in_ready=1 regardless of clock.
REQ-025 SHALL discard any partial frame or pending EMIT on reset mid-operation; first transfer after deassertion starts a fresh frame.

Configuration
REQ-026 SHALL, when macro ACC_SATURATE_EN is defined, clamp acc at 255 on carry-out (acc stays 255 for the rest of the frame) and still set out_overflow.
REQ-027 SHALL, when ACC_SATURATE_EN is undefined, wrap per REQ-022; all other behaviour identical.

Verification
REQ-028 SHALL cover: COUNT=4, samples 6,2,0,5 back-to-back, out_ready=1 -> out_valid one cycle after 4th transfer, out_data=13, out_overflow=0, in_ready=1 next cycle.
REQ-029 SHALL cover: COUNT=4, samples 3,3,3,3 with in_valid gaps of 2 cycles, out_ready=0 for 5 cycles -> out_data=12 held stable, in_ready=0 throughout EMIT, transfer on 6th cycle then IDLE.
REQ-030 SHALL cover: COUNT=40, all samples 7 -> default build out_data=24 (280 mod 256), out_overflow=1; ACC_SATURATE_EN build out_data=255, out_overflow=1.
REQ-031 SHALL cover: COUNT=1, sample 5 -> out_valid next cycle with out_data=5; sample offered during EMIT accepted only after output transfer.
REQ-032 SHALL cover: COUNT=4, reset asserted after 2 samples (and separately during EMIT) -> outputs zero immediately, next 4 samples 1,1,1,1 give out_data=4.
